// File: rtl/l2_config_and_types.sv
// Shared L2 request format, burst helpers and the memory-bridge FSM encoding.
package l2_config_and_types;

    localparam int L2_SUB_ID_W = 2;
    localparam int L2_BURST_W  = 5;
    localparam int L2_LEN_W    = L2_BURST_W + 1;

    typedef struct packed {
        logic [29:0]             addr;
        logic                    rnw;
        logic [3:0]              be;
        logic                    is_amo;
        logic [L2_BURST_W-1:0]   amo_type_or_burst_size;
        logic [L2_SUB_ID_W-1:0]  sub_id;
    } l2_request_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT
    } l2_mem_bridge_state_t;

    function automatic logic [L2_LEN_W-1:0] burst_len(input logic [L2_BURST_W-1:0] size);
        return {1'b0, size} + L2_LEN_W'(1);
    endfunction

    function automatic logic len_is_pow2(input logic [L2_LEN_W-1:0] len);
        return (len & (len - L2_LEN_W'(1))) == '0;
    endfunction

    // Low log2(len) address bits wrap inside the aligned block; upper bits stay fixed.
    function automatic logic [29:0] wrap_addr(input logic [29:0] base,
                                              input logic [L2_LEN_W-1:0] idx,
                                              input logic [L2_LEN_W-1:0] len);
        logic [29:0] mask;
        mask = 30'(len - L2_LEN_W'(1));
        return (base & ~mask) | ((base + 30'(idx)) & mask);
    endfunction

endpackage

// File: rtl/l2_requester_interface.sv
// L1-arbiter to L2 request/data/return channel.
interface l2_requester_interface;
    import l2_config_and_types::*;

    l2_request_t             request;
    logic                    request_push;
    logic                    request_full;

    logic [31:0]             wr_data;
    logic                    wr_data_push;
    logic                    data_full;

    logic [31:0]             rd_data;
    logic [L2_SUB_ID_W-1:0]  rd_sub_id;
    logic                    rd_data_valid;
    logic                    rd_data_ack;

    logic                    con_result;
    logic                    con_valid;

    logic                    inv_valid;
    logic [29:0]             inv_addr;

    modport master (
        output request, request_push, wr_data, wr_data_push, rd_data_ack,
        input  request_full, data_full, rd_data, rd_sub_id, rd_data_valid,
               con_result, con_valid, inv_valid, inv_addr
    );

    modport slave (
        input  request, request_push, wr_data, wr_data_push, rd_data_ack,
        output request_full, data_full, rd_data, rd_sub_id, rd_data_valid,
               con_result, con_valid, inv_valid, inv_addr
    );
endinterface

// File: rtl/cva5_fifo.sv
// Generic power-of-two FIFO with head visible as data_out while valid.
// Latency: push visible at head next cycle; full/valid update the cycle after push/pop.
// Backpressure: full blocks push unless a pop frees a slot in the same cycle.
module cva5_fifo #(
    parameter type DATA_TYPE = logic,
    parameter int  DEPTH     = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  DATA_TYPE data_in,
    output DATA_TYPE data_out,
    output logic     valid,
    output logic     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    DATA_TYPE      mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign valid    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & valid;
    assign do_push  = push & (~full | do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/l2_mem_bridge.sv
// L2 endpoint: executes buffered L1 requests on a pipelined word memory port, reads as wrapping bursts.
// Latency: push to mem_req >= 2 cycles; mem_rvalid to rd_data_valid 1 cycle.
// Backpressure: request_full/data_full toward the arbiter; mem_ready stalls issue; returns are never stalled.
module l2_mem_bridge
    import l2_config_and_types::*;
#(
    parameter int REQ_DEPTH  = 4,
    parameter int DATA_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_requester_interface.slave l2,
    output logic                 mem_req,
    input  logic                 mem_ready,
    output logic [29:0]          mem_addr,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata
);
    l2_mem_bridge_state_t    state;
    l2_mem_bridge_state_t    next_state;

    l2_request_t             req_head;
    logic                    req_valid;
    logic                    req_pop;
    logic [31:0]             data_head;
    logic                    data_valid;
    logic                    data_pop;

    logic                    accept;
    logic                    issue_done;
    logic                    ret_accept;
    logic                    start_read;
    logic                    start_write;

    logic [29:0]             base_addr;
    logic [L2_LEN_W-1:0]     len;
    logic [L2_LEN_W-1:0]     issue_cnt;
    logic [L2_LEN_W-1:0]     ret_cnt;
    logic [L2_SUB_ID_W-1:0]  sub_id;

    logic                    rd_valid_q;
    logic [31:0]             rd_data_q;
    logic [L2_SUB_ID_W-1:0]  rd_sub_id_q;

    cva5_fifo #(.DATA_TYPE(l2_request_t), .DEPTH(REQ_DEPTH)) req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (l2.request_push),
        .pop      (req_pop),
        .data_in  (l2.request),
        .data_out (req_head),
        .valid    (req_valid),
        .full     (l2.request_full)
    );

    cva5_fifo #(.DATA_TYPE(logic [31:0]), .DEPTH(DATA_DEPTH)) data_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (l2.wr_data_push),
        .pop      (data_pop),
        .data_in  (l2.wr_data),
        .data_out (data_head),
        .valid    (data_valid),
        .full     (l2.data_full)
    );

    assign accept     = mem_req & mem_ready;
    assign issue_done = accept && ((issue_cnt + L2_LEN_W'(1)) == len);
    assign ret_accept = mem_rvalid && ((state == READ_ISSUE) || (state == READ_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A write at the head blocks everything behind it until its data arrives.
    always_comb begin
        next_state  = state;
        req_pop     = 1'b0;
        data_pop    = 1'b0;
        start_read  = 1'b0;
        start_write = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_head.rnw) begin
                        start_read = 1'b1;
                        next_state = READ_ISSUE;
                    end else if (data_valid) begin
                        start_write = 1'b1;
                        next_state  = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    req_pop    = 1'b1;
                    data_pop   = 1'b1;
                    next_state = IDLE;
                end
            end
            READ_ISSUE: begin
                if (issue_done) begin
                    req_pop    = 1'b1;
                    next_state = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (ret_cnt == len)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            base_addr   <= '0;
            len         <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            sub_id      <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_sub_id_q <= '0;
        end else begin
            if (start_read) begin
                base_addr <= req_head.addr;
                len       <= burst_len(req_head.amo_type_or_burst_size);
                sub_id    <= req_head.sub_id;
                issue_cnt <= '0;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= req_head.addr;
                mem_be    <= req_head.be;
            end else if (start_write) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= req_head.addr;
                mem_be    <= req_head.be;
                mem_wdata <= data_head;
            end else if ((state == WRITE) && accept) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end else if ((state == READ_ISSUE) && accept) begin
                issue_cnt <= issue_cnt + L2_LEN_W'(1);
                if (issue_done)
                    mem_req <= 1'b0;
                else
                    mem_addr <= wrap_addr(base_addr, issue_cnt + L2_LEN_W'(1), len);
            end

            // Returns may overlap issue; anything outside a read is stale and dropped.
            rd_valid_q <= ret_accept;
            if (start_read)
                ret_cnt <= '0;
            else if (ret_accept)
                ret_cnt <= ret_cnt + L2_LEN_W'(1);
            if (ret_accept) begin
                rd_data_q   <= mem_rdata;
                rd_sub_id_q <= sub_id;
            end
        end
    end

    assign l2.rd_data       = rd_data_q;
    assign l2.rd_data_valid = rd_valid_q;
    assign l2.rd_sub_id     = rd_sub_id_q;
    assign l2.con_valid     = 1'b0;
    assign l2.con_result    = 1'b0;
    assign l2.inv_valid     = 1'b0;
    assign l2.inv_addr      = '0;

    amo_unsupported: assert property (@(posedge clk) disable iff (rst)
        (start_read || start_write) |-> !req_head.is_amo);
    burst_len_pow2: assert property (@(posedge clk) disable iff (rst)
        start_read |-> len_is_pow2(burst_len(req_head.amo_type_or_burst_size)));
    no_return_backpressure: assert property (@(posedge clk) disable iff (rst)
        l2.rd_data_ack == l2.rd_data_valid);

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Scoreboard bench for l2_mem_bridge: directed requests, latency-2 memory responder, decoupled monitor.
module tb_l2_mem_bridge;
    import l2_config_and_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_ready, mem_we, mem_rvalid;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    l2_requester_interface l2_if ();
    assign l2_if.rd_data_ack = l2_if.rd_data_valid;

    l2_mem_bridge #(.REQ_DEPTH(4), .DATA_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .l2         (l2_if),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  sub;
    } rd_t;
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    acc_t  exp_acc[$];
    rd_t   exp_rd[$];
    pend_t pend[$];
    int    acc_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rd_total = 0;
    int    wr_at_rd = -1;
    logic  inj = 1'b0;
    logic [29:0] t5_addr [4] = '{30'h52, 30'h53, 30'h50, 30'h51};

    function automatic logic [31:0] rdf(input logic [29:0] a);
        return {2'b00, a} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp_read(input logic [29:0] a, input logic [1:0] sub);
        exp_acc.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0});
        exp_rd.push_back('{data: rdf(a), sub: sub});
    endtask

    task automatic push_req(input logic [29:0] a, input logic rnw, input logic [3:0] be,
                            input logic [4:0] sz, input logic [1:0] sub);
        l2_if.request      = '{addr: a, rnw: rnw, be: be, is_amo: 1'b0,
                               amo_type_or_burst_size: sz, sub_id: sub};
        l2_if.request_push = 1'b1;
        @(posedge clk); #1;
        l2_if.request_push = 1'b0;
    endtask

    task automatic push_data(input logic [31:0] d);
        l2_if.wr_data      = d;
        l2_if.wr_data_push = 1'b1;
        @(posedge clk); #1;
        l2_if.wr_data_push = 1'b0;
    endtask

    task automatic drain(input string nm, input int max);
        int n = 0;
        while ((exp_acc.size() != 0 || exp_rd.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_acc.size() != 0 || exp_rd.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout acc_left=%0d rd_left=%0d", nm, exp_acc.size(), exp_rd.size());
            exp_acc.delete();
            exp_rd.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_rst_vals(input string p);
        check({p, "_mem_req"},      32'(mem_req), 0);
        check({p, "_mem_we"},       32'(mem_we), 0);
        check({p, "_mem_addr"},     32'(mem_addr), 0);
        check({p, "_mem_be"},       32'(mem_be), 0);
        check({p, "_mem_wdata"},    mem_wdata, 0);
        check({p, "_rd_valid"},     32'(l2_if.rd_data_valid), 0);
        check({p, "_rd_data"},      l2_if.rd_data, 0);
        check({p, "_rd_sub_id"},    32'(l2_if.rd_sub_id), 0);
        check({p, "_request_full"}, 32'(l2_if.request_full), 0);
        check({p, "_data_full"},    32'(l2_if.data_full), 0);
        check({p, "_con_valid"},    32'(l2_if.con_valid | l2_if.con_result), 0);
        check({p, "_inv"},          32'(l2_if.inv_valid) | 32'(l2_if.inv_addr), 0);
        check({p, "_state"},        32'(dut.state), 32'(IDLE));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: fixed latency 2, in-order, plus an injection window for stray returns.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = inj;
            if (inj)
                mem_rdata = 32'hFEED_0000;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].data;
                void'(pend.pop_front());
            end
        end
    end

    initial forever begin
        acc_t e;
        rd_t  r;
        @(negedge clk);
        if (mem_req && mem_ready) begin
            acc_cyc.push_back(cyc);
            if (!mem_we)
                pend.push_back('{due: cyc + 2, data: rdf(mem_addr)});
            else
                wr_at_rd = rd_total;
            if (exp_acc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL acc_unexpected actual_addr=0x%0h we=%0b expected=none", mem_addr, mem_we);
            end else begin
                e = exp_acc.pop_front();
                check("acc_addr", 32'(mem_addr), 32'(e.addr));
                check("acc_we", 32'(mem_we), 32'(e.we));
                check("acc_be", 32'(mem_be), 32'(e.be));
                if (e.we)
                    check("acc_wdata", mem_wdata, e.wdata);
            end
        end
        if (l2_if.rd_data_valid) begin
            rd_total++;
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual_data=0x%0h expected=none", l2_if.rd_data);
            end else begin
                r = exp_rd.pop_front();
                check("rd_data", l2_if.rd_data, r.data);
                check("rd_sub_id", 32'(l2_if.rd_sub_id), 32'(r.sub));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int idx;
        int base;
        mem_ready          = 1'b1;
        l2_if.request      = '0;
        l2_if.request_push = 1'b0;
        l2_if.wr_data      = '0;
        l2_if.wr_data_push = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: wrapping read burst of 4 from 0x43
        acc_cyc.delete();
        exp_read(30'h43, 2'd1); exp_read(30'h40, 2'd1);
        exp_read(30'h41, 2'd1); exp_read(30'h42, 2'd1);
        push_req(30'h43, 1'b1, 4'hF, 5'd3, 2'd1);
        drain("t1", 60);
        check("t1_acc_count", acc_cyc.size(), 4);
        if (acc_cyc.size() == 4)
            check("t1_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
        check("t1_idle", 32'(dut.state), 32'(IDLE));

        // 2: write whose data arrives 3 cycles late
        exp_acc.push_back('{addr: 30'h10, we: 1'b1, be: 4'h5, wdata: 32'hDEADBEEF});
        push_req(30'h10, 1'b0, 4'h5, 5'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_no_req_without_data", 32'(mem_req), 0);
            @(posedge clk); #1;
        end
        push_data(32'hDEADBEEF);
        drain("t2", 40);
        check("t2_req_fifo_empty", 32'(dut.req_valid), 0);
        check("t2_data_fifo_empty", 32'(dut.data_valid), 0);

        // 3: fill the request FIFO while memory stalls
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_read(30'h100 + 30'(i), 2'd2);
        push_req(30'h100, 1'b1, 4'hF, 5'd0, 2'd2);
        push_req(30'h101, 1'b1, 4'hF, 5'd0, 2'd2);
        push_req(30'h102, 1'b1, 4'hF, 5'd0, 2'd2);
        check("t3_not_full_at_3", 32'(l2_if.request_full), 0);
        push_req(30'h103, 1'b1, 4'hF, 5'd0, 2'd2);
        check("t3_full_at_4", 32'(l2_if.request_full), 1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t3_full_during_pop", 32'(l2_if.request_full), 1);
        @(posedge clk); #1;
        check("t3_full_drops", 32'(l2_if.request_full), 0);
        drain("t3", 80);

        // 4: burst-8 read followed by a queued write
        base = rd_total;
        exp_read(30'h205, 2'd3); exp_read(30'h206, 2'd3);
        exp_read(30'h207, 2'd3); exp_read(30'h200, 2'd3);
        exp_read(30'h201, 2'd3); exp_read(30'h202, 2'd3);
        exp_read(30'h203, 2'd3); exp_read(30'h204, 2'd3);
        exp_acc.push_back('{addr: 30'h300, we: 1'b1, be: 4'hF, wdata: 32'h12345678});
        push_req(30'h205, 1'b1, 4'hF, 5'd7, 2'd3);
        push_req(30'h300, 1'b0, 4'hF, 5'd0, 2'd0);
        push_data(32'h12345678);
        drain("t4", 100);
        check("t4_write_after_8_returns", wr_at_rd, base + 8);

        // 5: mem_ready toggling during a burst of 4
        for (int i = 0; i < 4; i++)
            exp_read(t5_addr[i], 2'd0);
        push_req(30'h52, 1'b1, 4'hF, 5'd3, 2'd0);
        idx = 0;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            mem_ready = (i % 2 == 1);
            @(negedge clk);
            if (mem_req) begin
                check("t5_addr_hold_or_advance", 32'(mem_addr), 32'(t5_addr[idx]));
                if (mem_ready)
                    idx++;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        check("t5_words_issued", idx, 4);
        drain("t5", 60);

        // 6: reset after 2 of 4 returns, then stray returns
        exp_read(30'h80, 2'd1); exp_read(30'h81, 2'd1);
        exp_read(30'h82, 2'd1); exp_read(30'h83, 2'd1);
        push_req(30'h80, 1'b1, 4'hF, 5'd3, 2'd1);
        n = 0;
        while (exp_rd.size() > 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_two_returns_seen", exp_rd.size(), 2);
        rst = 1'b1;
        exp_rd.delete();
        exp_acc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        inj = 1'b1;
        repeat (2) @(negedge clk);
        inj = 1'b0;
        repeat (3) @(negedge clk);
        check_rst_vals("t6");
        check("t6_total_returns", rd_total - base, 8 + 4 + 2);

        check("end_acc_queue_empty", exp_acc.size(), 0);
        check("end_rd_queue_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_mem_bridge.md
# l2_mem_bridge

Downstream consumer of the L1 arbiter's L2 requester port. It buffers arbitrated L1 requests and write data in two FIFOs, then executes them one at a time against a simple pipelined word-wide memory port. Reads are issued as wrapping bursts, and the returned words are tagged with the requester's sub_id. It is the L2 endpoint for configurations without an L2 cache.

## Interface
- REQ_DEPTH, 4: request FIFO depth; power of two, ≥2.
- DATA_DEPTH, 8: write-data FIFO depth; power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- l2  l2_requester_interface.slave  —  consumes the arbiter's request/data pushes and drives all of the following:
  - request_full, data_full
  - rd_data, rd_data_valid, rd_sub_id
  - con_valid, con_result
  - inv_valid, inv_addr
- mem_req  out  1  memory access valid.
- mem_ready  in  1  memory accepts the access this cycle.
- mem_addr  out  30  word address.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_rvalid  in  1  read word returned; in order, any latency ≥1.
- mem_rdata  in  32  returned word.

## Operation
- Request FIFO:
  - Pushed on l2.request_push with {addr, rnw, be, is_amo, amo_type_or_burst_size, sub_id}.
  - request_full = (count == REQ_DEPTH).
- Data FIFO:
  - Pushed on l2.wr_data_push with l2.wr_data.
  - data_full = (count == DATA_DEPTH).
- Pushing into a full FIFO is a protocol error, flagged by an assertion; contents stay unchanged.
- Not supported:
  - con_valid, con_result, inv_valid and inv_addr are tied to 0.
  - is_amo=1 is treated as a plain access, and an assertion fires.
- Burst length len = amo_type_or_burst_size+1 for reads; writes are always 1 word.
- len must be a power of two (assertion). With k = log2(len), the word address for index i is {addr[29:k], (addr[k-1:0]+i) mod len}.
- FSM states: IDLE, WRITE, READ_ISSUE, READ_WAIT.
  - IDLE → WRITE: request FIFO non-empty with rnw=0 and data FIFO non-empty. A write waiting on data stays in IDLE.
  - IDLE → READ_ISSUE: request FIFO non-empty with rnw=1. Latch head, set issue_cnt = 0, ret_cnt = 0.
  - WRITE: hold mem_req=1, mem_we=1, be, and the data head. On mem_ready, pop both FIFOs and go to IDLE.
  - READ_ISSUE: mem_req=1, mem_we=0. Each mem_ready increments issue_cnt. When issue_cnt reaches len, pop the request FIFO and go to READ_WAIT.
  - READ_WAIT: when ret_cnt == len, go to IDLE.
- Read return: each mem_rvalid in READ_ISSUE or READ_WAIT increments ret_cnt and registers the word to rd_data, with rd_data_valid=1 and rd_sub_id = latched sub_id.
- mem_rvalid in IDLE or WRITE is dropped.
- Returns may overlap issue (mem_rvalid arriving during READ_ISSUE).
- No return backpressure: rd_data_ack must equal rd_data_valid (assertion).
- Requests execute strictly in FIFO order; there is no read/write reordering.

## Timing
- Reset values:
  - FIFOs empty; full flags 0.
  - FSM in IDLE; counters 0.
  - mem_req, mem_we, rd_data_valid = 0.
  - mem_addr, mem_be, mem_wdata, rd_data, rd_sub_id = 0.
- Memory-side outputs are registered.
- A request pushed in cycle N is visible at the FIFO head in N+1; mem_req rises at N+2 at the earliest.
- Full flags update the cycle after a push or pop. A push and pop in the same cycle on a full FIFO is legal, and the flag stays 1.
- Issue throughput is one word per cycle while mem_ready=1. mem_addr advances in the cycle following each accept.
- mem_rvalid in cycle M produces rd_data_valid in cycle M+1 for exactly one cycle.
- From READ_WAIT, the last return allows IDLE one cycle later. The next request's mem_req follows one cycle after that.
- Asynchronous reset mid-burst aborts immediately. Late mem_rvalid arriving after reset is dropped.

## Structure
- Add l2_mem_bridge_state_t (the FSM enum) to l2_config_and_types, alongside l2_request_t.
- The burst-length limit comes from the existing width of amo_type_or_burst_size.
- Use two instances of the existing generic cva5_fifo sub-module: one for requests, one for data.
- The FSM, address wrap logic and counters live in this block.

## Test plan
- Read, addr 0x43, burst_size 3, sub_id 1, mem_ready=1, latency 2 → mem_addr 0x43, 0x40, 0x41, 0x42 on consecutive cycles; rd_data_valid ×4 with rd_sub_id=1; FSM returns to IDLE.
- Write, addr 0x10, be 0b0101, data 0xDEADBEEF, with data pushed 3 cycles after the request → no mem_req until data arrives; then a single access with we=1, be=0x5; both FIFOs empty afterwards.
- Push 4 requests with mem_ready=0 → request_full=1 after the 4th push. Release mem_ready → request_full drops the cycle after the first pop.
- Read (burst 8) followed by a queued write → write mem_req appears only after the 8th rd_data_valid.
- mem_ready toggling 1,0,1,0 during a burst of 4 → addresses advance only on accepted cycles; 4 returns.
- Assert rst after 2 of 4 returns, then inject 2 more mem_rvalid → no rd_data_valid; all outputs at reset values.
